// File: rtl/conv_feeder.sv
// rtl/conv_feeder.sv - 3x3 convolution feeder: emits kernel columns, then sliding 3-row image columns
module conv_feeder #(
  parameter int BIT_LEN = 8,
  parameter int M_LEN   = 3,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_valid,
  input  logic signed [BIT_LEN-1:0] i_data,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic                      o_selecK_I,
  output logic signed [BIT_LEN-1:0] o_data0,
  output logic signed [BIT_LEN-1:0] o_data1,
  output logic signed [BIT_LEN-1:0] o_data2,
  output logic                      o_row_start,
  output logic                      o_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_KLOAD, S_FILL, S_STREAM, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    k_row_q, k_row_d;
  logic [1:0]    k_col_q, k_col_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  // Set when the last pixel has been accepted; the emit cycle drains before DONE.
  logic          fin_q, fin_d;

  logic signed [BIT_LEN-1:0] w0_q, w0_d, w1_q, w1_d;

  // lb0 holds row y-2, lb1 holds row y-1 relative to the incoming row.
  logic signed [BIT_LEN-1:0] lb0_q [IMG_W];
  logic signed [BIT_LEN-1:0] lb0_d [IMG_W];
  logic signed [BIT_LEN-1:0] lb1_q [IMG_W];
  logic signed [BIT_LEN-1:0] lb1_d [IMG_W];

  logic                      valid_q, valid_d;
  logic                      ready_q, ready_d;
  logic                      sel_q, sel_d;
  logic                      row_start_q, row_start_d;
  logic                      done_q, done_d;
  logic signed [BIT_LEN-1:0] data0_q, data0_d;
  logic signed [BIT_LEN-1:0] data1_q, data1_d;
  logic signed [BIT_LEN-1:0] data2_q, data2_d;

  logic accept;
  logic k_row_last;
  logic k_last;
  logic x_last;
  logic y_last;

  assign accept     = i_valid && ready_q;
  assign k_row_last = (k_row_q == 2'(M_LEN - 1));
  assign k_last     = k_row_last && (k_col_q == 2'(M_LEN - 1));
  assign x_last     = (x_q == XW'(IMG_W - 1));
  assign y_last     = (y_q == YW'(IMG_H - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_start) state_d = S_KLOAD;
      S_KLOAD:  if (accept && k_last) state_d = S_FILL;
      S_FILL:   if (accept && x_last && (y_q == YW'(1))) state_d = S_STREAM;
      S_STREAM: if (fin_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready tracks the accepting states, done marks the DONE cycle
  always_comb begin
    ready_d = ((state_d == S_KLOAD) || (state_d == S_FILL) || (state_d == S_STREAM)) && !fin_d;
    done_d  = (state_d == S_DONE);
  end

  // Datapath: counters, weight staging, line buffer and column outputs
  always_comb begin
    k_row_d     = k_row_q;
    k_col_d     = k_col_q;
    x_d         = x_q;
    y_d         = y_q;
    fin_d       = fin_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    lb0_d       = lb0_q;
    lb1_d       = lb1_q;
    valid_d     = 1'b0;
    row_start_d = 1'b0;
    sel_d       = sel_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          k_row_d = '0;
          k_col_d = '0;
          x_d     = '0;
          y_d     = '0;
          fin_d   = 1'b0;
        end
      end
      S_KLOAD: begin
        if (accept) begin
          if (k_row_last) begin
            valid_d = 1'b1;
            sel_d   = 1'b0;
            data0_d = w0_q;
            data1_d = w1_q;
            data2_d = i_data;
            k_row_d = '0;
            k_col_d = k_col_q + 2'd1;
          end else begin
            if (k_row_q == 2'd0) begin
              w0_d = i_data;
            end else begin
              w1_d = i_data;
            end
            k_row_d = k_row_q + 2'd1;
          end
        end
      end
      S_FILL: begin
        if (accept) begin
          if (y_q == '0) begin
            lb0_d[x_q] = i_data;
          end else begin
            lb1_d[x_q] = i_data;
          end
          x_d = x_last ? '0 : x_q + XW'(1);
          y_d = x_last ? y_q + YW'(1) : y_q;
        end
      end
      S_STREAM: begin
        if (accept) begin
          valid_d     = 1'b1;
          sel_d       = 1'b1;
          row_start_d = (x_q == '0);
          data0_d     = lb0_q[x_q];
          data1_d     = lb1_q[x_q];
          data2_d     = i_data;
          lb0_d[x_q]  = lb1_q[x_q];
          lb1_d[x_q]  = i_data;
          if (x_last && y_last) begin
            fin_d = 1'b1;
          end
          x_d = x_last ? '0 : x_q + XW'(1);
          y_d = x_last ? y_q + YW'(1) : y_q;
        end
      end
      S_DONE: begin
        fin_d = 1'b0;
      end
      default: begin
        fin_d = 1'b0;
      end
    endcase
  end

  // Control and output registers, cleared by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      k_row_q     <= '0;
      k_col_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      fin_q       <= 1'b0;
      w0_q        <= '0;
      w1_q        <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
      sel_q       <= 1'b0;
      row_start_q <= 1'b0;
      done_q      <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
    end else begin
      k_row_q     <= k_row_d;
      k_col_q     <= k_col_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fin_q       <= fin_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      sel_q       <= sel_d;
      row_start_q <= row_start_d;
      done_q      <= done_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
    end
  end

  // Line buffer storage; never read before FILL rewrites it, so no reset
  always_ff @(posedge i_clk) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_selecK_I  = sel_q;
  assign o_row_start = row_start_q;
  assign o_done      = done_q;
  assign o_data0     = data0_q;
  assign o_data1     = data1_q;
  assign o_data2     = data2_q;

endmodule
